// File: rtl/select_de_multi_pkg.sv
// de_pkg: shared types and the die face table for the dice-type selector.
// Optional feature macro used by the selector files: SELECT_DE_AUTOREPEAT_EN.

package de_pkg;

  localparam int NB_TYPES_MAX = 8;

  typedef logic [2:0] id_t;
  typedef logic [3:0] nb_t;
  typedef logic [6:0] face_t;

  localparam face_t FACES [NB_TYPES_MAX] = '{
    7'd2, 7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd100
  };

  function automatic face_t faces_of(input id_t id);
    return FACES[id];
  endfunction

endpackage

// File: rtl/select_de_multi_bouton_pulse.sv
// bouton_pulse: 2-FF synchroniser plus rising-edge detector for one raw button.
// With SELECT_DE_AUTOREPEAT_EN defined, a hold counter adds repeat steps while
// the button stays held and the top reports that holding is allowed.

module bouton_pulse
`ifdef SELECT_DE_AUTOREPEAT_EN
#(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
`ifdef SELECT_DE_AUTOREPEAT_EN
  input  logic hold_ok,
  output logic level,
`endif
  output logic step
);

  logic sync1, sync2, prev;

  // Bring the button into the clock domain and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

`ifdef SELECT_DE_AUTOREPEAT_EN
  localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);

  logic [CW-1:0] cnt;
  logic          rep_phase;
  logic          holding;
  logic          rep;

  assign level   = sync2;
  assign holding = sync2 & hold_ok;
  assign rep     = holding & (rep_phase ? (cnt == CW'(REPEAT_PERIOD))
                                        : (cnt == CW'(REPEAT_DELAY)));

  // Count cycles since the last step while held; first repeat after the long delay, then the short period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rep_phase <= 1'b0;
    end else if (!holding) begin
      cnt       <= '0;
      rep_phase <= 1'b0;
    end else if (rep) begin
      cnt       <= CW'(1);
      rep_phase <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
    end
  end

  assign step = (sync2 & ~prev) | rep;
`else
  assign step = sync2 & ~prev;
`endif

endmodule

// File: rtl/select_de_multi.sv
// select_de_multi: button-driven die type / dice count selector with registered
// roll bounds. Optional auto-repeat on held buttons via SELECT_DE_AUTOREPEAT_EN.

module select_de_multi
  import de_pkg::*;
#(
  parameter int N_TYPES       = 8,
  parameter int DEF_TYPE      = 2,
  parameter int MAX_NB        = 8,
  parameter int W_TOT         = 10,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             suivant,
  input  logic             precedent,
  input  logic             nb_plus,
  input  logic             verrou,
  output logic [2:0]       id_de,
  output logic [3:0]       nb_de,
  output logic [W_TOT-1:0] min_tot,
  output logic [W_TOT-1:0] max_tot,
  output logic             maj
);

  logic step_s, step_p, step_n;
  logic type_step, count_step, pend;
  id_t  id_next;
  nb_t  nb_next;

`ifdef SELECT_DE_AUTOREPEAT_EN
  logic lvl_s, lvl_p, lvl_n;

  bouton_pulse #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_suivant (
    .clk(clk), .rst_n(rst_n), .btn(suivant),
    .hold_ok(~verrou & ~lvl_p & ~lvl_n), .level(lvl_s), .step(step_s));
  bouton_pulse #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_precedent (
    .clk(clk), .rst_n(rst_n), .btn(precedent),
    .hold_ok(~verrou & ~lvl_s & ~lvl_n), .level(lvl_p), .step(step_p));
  bouton_pulse #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_nb_plus (
    .clk(clk), .rst_n(rst_n), .btn(nb_plus),
    .hold_ok(~verrou & ~lvl_s & ~lvl_p), .level(lvl_n), .step(step_n));
`else
  bouton_pulse u_suivant   (.clk(clk), .rst_n(rst_n), .btn(suivant),   .step(step_s));
  bouton_pulse u_precedent (.clk(clk), .rst_n(rst_n), .btn(precedent), .step(step_p));
  bouton_pulse u_nb_plus   (.clk(clk), .rst_n(rst_n), .btn(nb_plus),   .step(step_n));
`endif

  // Opposite type steps cancel; everything is dropped while a roll holds the lock
  assign type_step  = ~verrou & (step_s ^ step_p);
  assign count_step = ~verrou & step_n;

  // Next type/count values with wrap-around at both ends of the type range
  always_comb begin
    id_next = id_de;
    nb_next = nb_de;
    if (type_step) begin
      if (step_s)
        id_next = (id_de == id_t'(N_TYPES - 1)) ? id_t'(0) : id_de + id_t'(1);
      else
        id_next = (id_de == id_t'(0)) ? id_t'(N_TYPES - 1) : id_de - id_t'(1);
    end
    if (count_step)
      nb_next = (nb_de == nb_t'(MAX_NB)) ? nb_t'(1) : nb_de + nb_t'(1);
  end

  // Selection registers; pend marks that the bounds must be refreshed next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_de <= id_t'(DEF_TYPE);
      nb_de <= nb_t'(1);
      pend  <= 1'b0;
    end else begin
      id_de <= id_next;
      nb_de <= nb_next;
      pend  <= type_step | count_step;
    end
  end

  // Registered roll bounds, refreshed one cycle after an accepted step, with the update pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_tot <= W_TOT'(1);
      max_tot <= W_TOT'(faces_of(id_t'(DEF_TYPE)));
      maj     <= 1'b0;
    end else begin
      maj <= pend;
      if (pend) begin
        min_tot <= W_TOT'(nb_de);
        max_tot <= W_TOT'(nb_de) * W_TOT'(faces_of(id_de));
      end
    end
  end

endmodule

// File: tb/tb_select_de_multi.sv
// tb_select_de_multi: directed and randomized checks of select_de_multi against
// a behavioural model of the selection rules. Hold test follows SELECT_DE_AUTOREPEAT_EN.

module tb_select_de_multi;

  localparam int W_TOT = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             suivant = 1'b0, precedent = 1'b0, nb_plus = 1'b0, verrou = 1'b0;
  logic [2:0]       id_de;
  logic [3:0]       nb_de;
  logic [W_TOT-1:0] min_tot, max_tot;
  logic             maj;

  int checks = 0;
  int errors = 0;
  int maj_cnt = 0;

  int face_tab [8] = '{2, 4, 6, 8, 10, 12, 20, 100};
  int m_id = 2;
  int m_nb = 1;
  int exp_maj = 0;

  select_de_multi #(
    .N_TYPES(8), .DEF_TYPE(2), .MAX_NB(8), .W_TOT(W_TOT),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .suivant(suivant), .precedent(precedent),
    .nb_plus(nb_plus), .verrou(verrou), .id_de(id_de), .nb_de(nb_de),
    .min_tot(min_tot), .max_tot(max_tot), .maj(maj)
  );

  always #5 clk = ~clk;

  // Count update pulses away from the active edge
  always @(negedge clk) if (maj === 1'b1) maj_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".id"},  32'(id_de),   32'(m_id));
    chk({tag, ".nb"},  32'(nb_de),   32'(m_nb));
    chk({tag, ".min"}, 32'(min_tot), 32'(m_nb));
    chk({tag, ".max"}, 32'(max_tot), 32'(m_nb * face_tab[m_id]));
    chk({tag, ".maj"}, 32'(maj),     32'(0));
    chk({tag, ".majcnt"}, 32'(maj_cnt), 32'(exp_maj));
  endtask

  // Model of one press: opposite type steps cancel, count wraps MAX_NB->1, lock drops all
  task automatic applyStimulus(input bit s, input bit p, input bit n, input bit lock);
    verrou = lock;
    suivant = s; precedent = p; nb_plus = n;
    tick(3);
    suivant = 1'b0; precedent = 1'b0; nb_plus = 1'b0;
    tick(6);
    verrou = 1'b0;
    tick(1);
    if (!lock) begin
      if (s && !p) m_id = (m_id + 1) % 8;
      if (p && !s) m_id = (m_id + 7) % 8;
      if (n) m_nb = (m_nb == 8) ? 1 : m_nb + 1;
      if ((s != p) || n) exp_maj++;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    m_id = 2; m_nb = 1;
    exp_maj = maj_cnt;
  endtask

  initial begin
    int steps;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("reset_hold");
    end

    // Single suivant press, cycle-accurate latency
    suivant = 1'b1;
    tick(1);
    chk("lat.k", 32'(id_de), 32'd2);
    tick(1);
    chk("lat.k1", 32'(id_de), 32'd2);
    tick(1);
    chk("lat.k2.id", 32'(id_de), 32'd3);
    chk("lat.k2.max", 32'(max_tot), 32'd6);
    chk("lat.k2.maj", 32'(maj), 32'd0);
    tick(1);
    chk("lat.k3.max", 32'(max_tot), 32'd8);
    chk("lat.k3.maj", 32'(maj), 32'd1);
    suivant = 1'b0;
    tick(1);
    chk("lat.k4.maj", 32'(maj), 32'd0);
    tick(4);
    m_id = 3; exp_maj = 1;
    checkOutput("first_step");

    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("wrap_fwd");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("at_zero");
    applyStimulus(0, 1, 0, 0);
    checkOutput("wrap_back");

    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("d20_x4");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("nb_wrap");

    applyStimulus(1, 1, 0, 0);
    checkOutput("both_types");
    doReset();
    applyStimulus(1, 0, 1, 0);
    checkOutput("type_and_count");

    applyStimulus(1, 0, 0, 1);
    checkOutput("locked_press");
    verrou = 1'b1;
    suivant = 1'b1;
    tick(5);
    verrou = 1'b0;
    tick(6);
    checkOutput("held_through_unlock");
    suivant = 1'b0;
    tick(4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("after_unlock");

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      checkOutput($sformatf("rand%0d", i));
    end

    // Reset between step and bound refresh
    suivant = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    m_id = 2; m_nb = 1;
    chk("midrst.id",  32'(id_de),   32'd2);
    chk("midrst.max", 32'(max_tot), 32'd6);
    chk("midrst.maj", 32'(maj),     32'd0);
    suivant = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checkOutput("midrst_after");

    // Long hold: one step, plus repeats when auto-repeat is built in
    suivant = 1'b1;
    tick(30);
    suivant = 1'b0;
    tick(8);
`ifdef SELECT_DE_AUTOREPEAT_EN
    steps = 6;
`else
    steps = 1;
`endif
    m_id = (m_id + steps) % 8;
    exp_maj += steps;
    checkOutput("hold30");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_de_multi.md
Name: select_de_multi

Overview:
- Clocked, parametrised successor to the dice-type selector.
- Picks a die type from a fixed face table (d2…d100) and a dice count of 1..MAX_NB.
- Buttons step the type forward or back and step the count.
- Registered outputs: die id, count, and total roll bounds (min = count, max = count × faces). These feed the roll generator and the display converter.

Parameters:
- N_TYPES, 8, number of die types used from the face table (2..8).
- DEF_TYPE, 2, type index after reset (2 = d6).
- MAX_NB, 8, maximum dice count (1..15).
- W_TOT, 10, width of the total bounds; must hold MAX_NB×100.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat step (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 5000000, cycles between later repeat steps (AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- suivant  in  1  raw button: next die type
- precedent  in  1  raw button: previous die type
- nb_plus  in  1  raw button: count +1
- verrou  in  1  high while a roll is in progress; freezes the selection
- id_de  out  3  current type index, 0..N_TYPES-1
- nb_de  out  4  current dice count, 1..MAX_NB
- min_tot  out  W_TOT  minimum total = nb_de
- max_tot  out  W_TOT  maximum total = nb_de × faces(id_de)
- maj  out  1  one-cycle pulse when min_tot/max_tot take new values

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - id_de = DEF_TYPE, nb_de = 1, min_tot = 1, max_tot = faces(DEF_TYPE), maj = 0.
  - Synchroniser and edge registers cleared.
- Each button passes through a 2-FF synchroniser, then a rising-edge detector, giving a 1-cycle step pulse.
  - A rise sampled at edge k produces the step at edge k+2.
  - id_de/nb_de update at edge k+2.
  - min_tot/max_tot update at edge k+3; maj is high for the cycle after edge k+3.
- Type stepping:
  - suivant: id_de+1, wraps N_TYPES-1 → 0.
  - precedent: id_de-1, wraps 0 → N_TYPES-1.
  - Both step pulses in the same cycle: no change, no maj.
- Count stepping: nb_plus gives nb_de+1, wraps MAX_NB → 1. A type step and a count step in the same cycle both apply.
- verrou high:
  - Step pulses are discarded, not queued.
  - Edge-detect history keeps tracking, so a button already held when verrou falls does not step.
- Arithmetic:
  - max_tot is the registered product nb_de × faces, zero-extended to W_TOT.
  - min_tot is nb_de zero-extended.
  - No overflow if W_TOT is parametrised correctly.
- Face table: 2, 4, 6, 8, 10, 12, 20, 100 for index 0..7.
- maj pulses only when a step is accepted; it never pulses after reset.
- Reset asserted mid-operation (between a step and the bound update) restores reset values; no maj follows.

Optional Feature:
- Macro: SELECT_DE_AUTOREPEAT_EN.
- Defined:
  - While suivant, precedent or nb_plus stays high (synchronised) and verrou is low, a hold counter runs.
  - At REPEAT_DELAY cycles after the initial step, a further step is issued, then one every REPEAT_PERIOD cycles.
  - Release or verrou resets the counter.
  - If two buttons are held, the counter resets and no repeat is issued.
- Undefined: one step per press only; no hold counters are synthesised.

Decomposition:
- Package de_pkg holds:
  - FACES constant array (8 × 7 bits) and function faces_of(id).
  - Type-index typedef (3 bits) and count typedef (4 bits).
  - NB_TYPES_MAX = 8.
- Sub-module bouton_pulse: synchroniser, edge detector and optional repeat counter, instantiated three times.

Test Plan:
- Reset release → id_de=2, nb_de=1, min_tot=1, max_tot=6, maj=0 for 20 cycles.
- Single suivant press from reset → id_de=3 at edge k+2; max_tot=8 and maj=1 one cycle later. Seven more presses → wraps to id_de=2. precedent from id_de=0 → id_de=7, max_tot=nb×100.
- nb_plus pressed 3 times at id_de=6 (d20) → nb_de=4, min_tot=4, max_tot=80. Press 5 more with MAX_NB=8 → nb_de wraps to 1, max_tot=20.
- suivant and precedent rising in the same cycle → id_de unchanged, no maj. suivant and nb_plus together from reset → id_de=3, nb_de=2, max_tot=16, one maj.
- verrou high during press → no change. Button held while verrou falls → no step. Press after verrou low → normal step.
- With SELECT_DE_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4: hold suivant 30 cycles → one initial step plus steps at +10, +14, +18, +22, +26. Without the macro → exactly one step.
